// File: rtl/div_issue_unit.sv
// rtl/div_issue_unit.sv - DIV/DIVU/REM/REMU issue and sign-correction stage ahead of an iterative unsigned divider
// Zero divisor and signed overflow are answered locally; all other ops go through the divider.
module div_issue_unit #(
    parameter int N    = 16,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [N-1:0]    in_rs1,
    input  logic [N-1:0]    in_rs2,
    input  logic [TAGW-1:0] in_tag,
    output logic            div_req,
    output logic [N-1:0]    div_a,
    output logic [N-1:0]    div_b,
    input  logic            div_done,
    input  logic [N-1:0]    div_q,
    input  logic [N-1:0]    div_r,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [N-1:0]    wb_data,
    output logic [TAGW-1:0] wb_tag,
    output logic            wb_dz,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [N-1:0] MIN_NEG  = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

    state_t            state_q;
    logic              in_ready_q;
    logic              busy_q;
    logic              div_req_q;
    logic              wb_valid_q;
    logic              wb_dz_q;
    logic              is_rem_q;
    logic              s1neg_q;
    logic              s2neg_q;
    logic [N-1:0]      div_a_q;
    logic [N-1:0]      div_b_q;
    logic [N-1:0]      wb_data_q;
    logic [TAGW-1:0]   wb_tag_q;

    logic              in_signed;
    logic              rs1_neg;
    logic              rs2_neg;
    logic              rs2_zero;
    logic              ovf;
    logic [N-1:0]      mag1;
    logic [N-1:0]      mag2;
    logic [N-1:0]      local_data;
    logic [N-1:0]      sel;
    logic              neg_res;
    logic [N-1:0]      corrected;

    always_comb begin
        in_signed  = ~in_op[0];
        rs1_neg    = in_signed & in_rs1[N-1];
        rs2_neg    = in_signed & in_rs2[N-1];
        rs2_zero   = (in_rs2 == '0);
        ovf        = in_signed && (in_rs1 == MIN_NEG) && (in_rs2 == ALL_ONES);
        // Negating 2^(N-1) wraps back to itself, which is exactly its unsigned magnitude.
        mag1       = rs1_neg ? -in_rs1 : in_rs1;
        mag2       = rs2_neg ? -in_rs2 : in_rs2;
        if (rs2_zero) begin
            local_data = in_op[1] ? in_rs1 : ALL_ONES;
        end else begin
            local_data = in_op[1] ? '0 : MIN_NEG;
        end
        sel        = is_rem_q ? div_r : div_q;
        // Remainder takes the dividend's sign; quotient is negative when signs differ.
        neg_res    = is_rem_q ? s1neg_q : (s1neg_q ^ s2neg_q);
        corrected  = neg_res ? -sel : sel;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            div_req_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_dz_q    <= 1'b0;
            is_rem_q   <= 1'b0;
            s1neg_q    <= 1'b0;
            s2neg_q    <= 1'b0;
            div_a_q    <= '0;
            div_b_q    <= '0;
            wb_data_q  <= '0;
            wb_tag_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        is_rem_q   <= in_op[1];
                        s1neg_q    <= rs1_neg;
                        s2neg_q    <= rs2_neg;
                        wb_tag_q   <= in_tag;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        wb_dz_q    <= rs2_zero;
                        if (rs2_zero || ovf) begin
                            wb_data_q  <= local_data;
                            wb_valid_q <= 1'b1;
                            state_q    <= RESP;
                        end else begin
                            div_a_q   <= mag1;
                            div_b_q   <= mag2;
                            div_req_q <= 1'b1;
                            state_q   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    div_req_q <= 1'b0;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    if (div_done) begin
                        wb_data_q  <= corrected;
                        wb_valid_q <= 1'b1;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    if (wb_ready) begin
                        wb_valid_q <= 1'b0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign div_req  = div_req_q;
    assign div_a    = div_a_q;
    assign div_b    = div_b_q;
    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign wb_tag   = wb_tag_q;
    assign wb_dz    = wb_dz_q;

endmodule

// File: tb/tb_div_issue_unit.sv
// tb/tb_div_issue_unit.sv - scoreboard bench for div_issue_unit with a fixed-latency divider model
module tb_div_issue_unit;

    localparam int N    = 16;
    localparam int TAGW = 5;
    localparam int LAT  = 4;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [N-1:0]    in_rs1;
    logic [N-1:0]    in_rs2;
    logic [TAGW-1:0] in_tag;
    logic            div_req;
    logic [N-1:0]    div_a;
    logic [N-1:0]    div_b;
    logic            div_done;
    logic [N-1:0]    div_q;
    logic [N-1:0]    div_r;
    logic            wb_valid;
    logic            wb_ready;
    logic [N-1:0]    wb_data;
    logic [TAGW-1:0] wb_tag;
    logic            wb_dz;
    logic            busy;

    div_issue_unit #(.N(N), .TAGW(TAGW)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .div_req(div_req), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_q(div_q), .div_r(div_r),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_tag(wb_tag), .wb_dz(wb_dz), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]      op;
        logic [N-1:0]    rs1;
        logic [N-1:0]    rs2;
        logic [TAGW-1:0] tag;
        logic [N-1:0]    data;
        logic            dz;
        logic            loc;
        logic [N-1:0]    a;
        logic [N-1:0]    b;
    } vec_t;

    typedef struct {
        logic [N-1:0]    data;
        logic [TAGW-1:0] tag;
        logic            dz;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    logic exp_req = 1'b0;
    logic [N-1:0] exp_a = '0;
    logic [N-1:0] exp_b = '0;
    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [N-1:0] rs1, input logic [N-1:0] rs2,
                                input logic [TAGW-1:0] tag, input logic [N-1:0] data, input logic dz,
                                input logic loc, input logic [N-1:0] a, input logic [N-1:0] b);
        vec_t r;
        r.op = op; r.rs1 = rs1; r.rs2 = rs2; r.tag = tag; r.data = data;
        r.dz = dz; r.loc = loc; r.a = a; r.b = b;
        return r;
    endfunction

    // Divider model: captures magnitudes while div_req is high, answers LAT cycles later.
    logic [N-1:0] ma, mb;
    initial begin
        div_done = 1'b0; div_q = '0; div_r = '0;
        forever begin
            @(negedge clk);
            if (div_req && rstn) begin
                ma = div_a; mb = div_b;
                repeat (LAT) @(posedge clk);
                #1;
                div_done = 1'b1;
                div_q = (mb != 0) ? ma / mb : '1;
                div_r = (mb != 0) ? ma % mb : ma;
                @(posedge clk);
                #1;
                div_done = 1'b0;
            end
        end
    end

    logic            held_v = 1'b0;
    logic [N-1:0]    held_d;
    logic [TAGW-1:0] held_t;
    logic            held_dz;
    logic            prev_req = 1'b0;
    exp_t            e;

    always @(negedge clk) begin
        if (rstn) begin
            if (wb_valid) chk("in_ready_in_resp", in_ready, 0);
            if (held_v && wb_valid) begin
                chk("bp_data_stable", wb_data, held_d);
                chk("bp_tag_stable", wb_tag, held_t);
                chk("bp_dz_stable", wb_dz, held_dz);
            end
            held_v = wb_valid && !wb_ready;
            held_d = wb_data; held_t = wb_tag; held_dz = wb_dz;
            if (wb_valid && wb_ready) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_result actual=%h expected=none", wb_data);
                end else begin
                    e = sb.pop_front();
                    chk("wb_data", wb_data, e.data);
                    chk("wb_tag", wb_tag, e.tag);
                    chk("wb_dz", wb_dz, e.dz);
                end
            end
            if (div_req) begin
                chk("req_expected", exp_req, 1);
                chk("req_single_pulse", prev_req, 0);
                chk("div_b_nonzero", div_b != 0, 1);
            end
            prev_req = div_req;
            if (exp_req && busy && !wb_valid) begin
                chk("div_a", div_a, exp_a);
                chk("div_b", div_b, exp_b);
            end
        end else begin
            held_v = 1'b0;
            prev_req = 1'b0;
        end
    end

    task automatic issue(input vec_t v);
        int n = 0;
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL ready_timeout actual=busy expected=ready");
        end
        in_valid = 1'b1; in_op = v.op; in_rs1 = v.rs1; in_rs2 = v.rs2; in_tag = v.tag;
        exp_req = !v.loc; exp_a = v.a; exp_b = v.b;
        sb.push_back('{data: v.data, tag: v.tag, dz: v.dz});
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (v.loc) begin
            chk("local_valid_next_cycle", wb_valid, 1);
        end else begin
            chk("issue_no_valid", wb_valid, 0);
            chk("issue_req", div_req, 1);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL done_timeout actual=pending expected=empty");
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_div_req", div_req, 0);
        chk("rst_div_a", div_a, 0);
        chk("rst_div_b", div_b, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_tag", wb_tag, 0);
        chk("rst_wb_dz", wb_dz, 0);
    endtask

    initial begin
        in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_tag = '0; wb_ready = 1'b1;
        //            op     rs1       rs2       tag  data      dz    loc   a         b
        vt[0]  = mk(2'b01, 16'd100,  16'd7,    1,  16'h000E, 1'b0, 1'b0, 16'd100,  16'd7);
        vt[1]  = mk(2'b11, 16'd100,  16'd7,    2,  16'h0002, 1'b0, 1'b0, 16'd100,  16'd7);
        vt[2]  = mk(2'b00, 16'hFFF9, 16'h0002, 3,  16'hFFFD, 1'b0, 1'b0, 16'd7,    16'd2);
        vt[3]  = mk(2'b10, 16'hFFF9, 16'h0002, 4,  16'hFFFF, 1'b0, 1'b0, 16'd7,    16'd2);
        vt[4]  = mk(2'b00, 16'h0007, 16'hFFFE, 5,  16'hFFFD, 1'b0, 1'b0, 16'd7,    16'd2);
        vt[5]  = mk(2'b01, 16'd5,    16'd0,    6,  16'hFFFF, 1'b1, 1'b1, 16'd0,    16'd0);
        vt[6]  = mk(2'b10, 16'd5,    16'd0,    7,  16'h0005, 1'b1, 1'b1, 16'd0,    16'd0);
        vt[7]  = mk(2'b00, 16'h8000, 16'hFFFF, 8,  16'h8000, 1'b0, 1'b1, 16'd0,    16'd0);
        vt[8]  = mk(2'b10, 16'h8000, 16'hFFFF, 9,  16'h0000, 1'b0, 1'b1, 16'd0,    16'd0);
        vt[9]  = mk(2'b00, 16'h8000, 16'h0002, 10, 16'hC000, 1'b0, 1'b0, 16'h8000, 16'd2);
        vt[10] = mk(2'b01, 16'hFFFF, 16'h0010, 11, 16'h0FFF, 1'b0, 1'b0, 16'hFFFF, 16'h0010);
        vt[11] = mk(2'b11, 16'hFFFF, 16'h0010, 12, 16'h000F, 1'b0, 1'b0, 16'hFFFF, 16'h0010);
        vt[12] = mk(2'b10, 16'h0007, 16'hFFFE, 13, 16'h0001, 1'b0, 1'b0, 16'd7,    16'd2);

        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals();
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            issue(vt[i]);
            wait_done();
        end

        // Backpressure: result held for three cycles while a new op is offered.
        wb_ready = 1'b0;
        issue(mk(2'b01, 16'd100, 16'd7, 20, 16'h000E, 1'b0, 1'b0, 16'd100, 16'd7));
        for (int n = 0; n < 50 && !wb_valid; n++) begin @(posedge clk); #1; end
        chk("bp_valid_rise", wb_valid, 1);
        in_valid = 1'b1; in_op = 2'b00; in_rs1 = 16'h1234; in_rs2 = 16'd3; in_tag = 5'd21;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp_valid_held", wb_valid, 1);
            chk("bp_in_ready_low", in_ready, 0);
        end
        in_valid = 1'b0;
        wb_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready_after", in_ready, 1);
        chk("bp_valid_after", wb_valid, 0);
        chk("bp_sb_empty", sb.size(), 0);

        // Reset while waiting on the divider; its late div_done must be ignored.
        issue(vt[2]);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        chk_reset_vals();
        void'(sb.pop_back());
        exp_req = 1'b0;
        @(posedge clk); #3;
        rstn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("stray_no_valid", wb_valid, 0);
            chk("stray_idle", busy, 0);
        end
        issue(vt[9]);
        wait_done();
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_issue_unit.md
# div_issue_unit

Issue and sign-correction stage directly upstream of the iterative unsigned divider. Accepts DIV/DIVU/REM/REMU operations from the execute stage and converts signed operands to magnitudes. It resolves divide-by-zero and signed overflow locally, launches the divider with a one-cycle request pulse, and applies sign correction to the returned quotient or remainder. The result is presented on a valid/ready writeback port with its destination tag.

## Interface
- N, 16, operand/result width (≥4)
- TAGW, 5, destination-register tag width
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept; equals (state==IDLE)
- in_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- in_rs1  in  N  dividend
- in_rs2  in  N  divisor
- in_tag  in  TAGW  destination tag
- div_req  out  1  one-cycle launch pulse to divider
- div_a  out  N  unsigned dividend magnitude, stable from div_req until div_done
- div_b  out  N  unsigned divisor magnitude, nonzero whenever div_req=1
- div_done  in  1  divider result valid this cycle (one-cycle pulse)
- div_q  in  N  unsigned quotient, sampled when div_done=1
- div_r  in  N  unsigned remainder, sampled when div_done=1
- wb_valid  out  1  result valid
- wb_ready  in  1  consumer accepts result
- wb_data  out  N  final result
- wb_tag  out  TAGW  tag of the op
- wb_dz  out  1  divisor was zero
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: in_valid at a clock edge latches op, tag, and operand signs, then selects the next state:
  - Divisor zero → RESP. wb_data = all-ones for DIV/DIVU, in_rs1 for REM/REMU. wb_dz=1.
  - Signed overflow (op DIV/REM, rs1=2^(N-1), rs2=all-ones) → RESP. wb_data = 2^(N-1) for DIV, 0 for REM. wb_dz=0.
  - Otherwise → ISSUE, with div_a/div_b loaded:
    - Signed ops: two's-complement magnitude of each negative operand. The magnitude of 2^(N-1) is 2^(N-1) unsigned (no overflow).
    - Unsigned ops: operands unchanged.
- ISSUE: div_req=1 for exactly this cycle → WAIT.
- WAIT: hold div_a/div_b. On div_done, select the result and register it → RESP:
  - Quotient (DIV/DIVU) or remainder (REM/REMU) is selected.
  - DIV: negate quotient if the operand signs differ.
  - REM: negate remainder if the dividend is negative.
  - DIVU/REMU: no correction.
- RESP: wb_valid=1; wb_data/wb_tag/wb_dz held stable while wb_ready=0. On wb_valid&&wb_ready → IDLE.
- div_done outside WAIT is ignored.
- All arithmetic is N-bit, wrap-around; the quotient negation of 2^(N-1) cannot occur (overflow is handled locally).

## Timing
- Reset values:
  - in_ready=1, busy=0.
  - div_req=0, div_a=0, div_b=0.
  - wb_valid=0, wb_data=0, wb_tag=0, wb_dz=0.
  - State IDLE.
- Divider path: accept at edge T; div_req high in cycle T+1; div_done in cycle T+1+L (L = divider latency); wb_valid high from T+2+L.
- Local path (zero divisor or overflow): wb_valid high in the cycle after accept; div_req never asserted.
- One op in flight. in_ready=0 from the cycle after accept through the wb handshake cycle. The earliest next accept is the cycle after the handshake.
- in_valid with in_ready=0 is held upstream; operands are not sampled.
- A wb_ready already high when wb_valid rises completes the handshake in that first RESP cycle.
- rstn low at any time, including in WAIT: asynchronous return to IDLE, all outputs to reset values, in-flight result discarded. The divider shares rstn.

## Test plan
- DIVU 100/7, then REMU 100/7 → wb_data 0x000E, then 0x0002. div_req is a single-cycle pulse with div_a=100 and div_b=7. wb_tag matches in_tag.
- DIV 0xFFF9/0x0002 (−7/2) → wb_data 0xFFFD. REM same operands → 0xFFFF. div_a=7, div_b=2. DIV 0x0007/0xFFFE → 0xFFFD.
- DIVU 5/0 → wb_data 0xFFFF, wb_dz=1, wb_valid one cycle after accept, div_req never high. REM 5/0 → 0x0005, wb_dz=1.
- DIV 0x8000/0xFFFF → 0x8000; REM 0x8000/0xFFFF → 0x0000; no div_req. DIV 0x8000/0x0002 → div_a=0x8000, result 0xC000.
- Backpressure: hold wb_ready=0 for 3 cycles in RESP → wb_valid, data, and tag stable; in_ready=0; in_valid ignored. Release → handshake, and in_ready=1 in the next cycle.
- Assert rstn low during WAIT, then pulse div_done after release → all outputs at reset values, state IDLE, stray div_done ignored, and the next op completes correctly.
